// File: rtl/inst_mem_pkg.sv
// Shared sizing helpers and configuration limits for the pipelined instruction memory.
package inst_mem_pkg;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int offset_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int index_w(input int data_w, input int depth_bytes);
        return $clog2(depth_bytes) - $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO for fetch responses; the head is visible combinationally.
module resp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, do_wr, do_rd;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign do_wr = push && !full;
    assign do_rd = pop && !empty;
    assign head  = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_mem_pipe.sv
// Byte-addressed instruction memory with a byte-enabled load port and a
// credit-controlled, fixed-latency fetch pipeline feeding a response FIFO.
module inst_mem_pipe
    import inst_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int READ_LAT    = 1,
    parameter int RESP_DEPTH  = READ_LAT + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                memW,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_err,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err,
    input  logic                resp_ready
);
    localparam int BPW      = bytes_per_word(DATA_W);
    localparam int OFFSET_W = offset_w(DATA_W);
    localparam int INDEX_W  = index_w(DATA_W, DEPTH_BYTES);
    localparam int DEPTH_AW = $clog2(DEPTH_BYTES);
    localparam int WORDS    = 1 << INDEX_W;
    localparam int STAGES   = READ_LAT - 1;
    localparam int CRED_W   = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } fetch_resp_t;

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("inst_mem_pipe: READ_LAT out of range");
    end

    // Misaligned, or any bit set above the storage range (no aliasing).
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a & ADDR_W'(BPW - 1)) != '0) || (a[ADDR_W-1:DEPTH_AW] != '0);
    endfunction

    logic [DATA_W-1:0] mem [WORDS];
    logic              wr_go, wr_bad, accept, resp_hs, req_bad, push, empty;
    logic [CRED_W-1:0] credits;
    fetch_resp_t       rd_now, push_d, head;

    assign wr_bad = memW && (|wr_be) && addr_bad(wr_addr);
    assign wr_go  = memW && !addr_bad(wr_addr);

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int k = 0; k < BPW; k++)
                if (wr_be[k]) mem[wr_addr[DEPTH_AW-1:OFFSET_W]][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= wr_bad;
    end

    // Storage is sampled combinationally at acceptance, so a same-edge write returns old data.
    assign accept      = req_valid && req_ready;
    assign req_bad     = addr_bad(req_addr);
    assign rd_now.err  = req_bad;
    assign rd_now.data = req_bad ? '0 : mem[req_addr[DEPTH_AW-1:OFFSET_W]];

    if (STAGES == 0) begin : g_nopipe
        assign push   = accept;
        assign push_d = rd_now;
    end else begin : g_pipe
        logic [STAGES:1] vld_pipe;
        fetch_resp_t     dat_pipe [STAGES:1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= accept;
                for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            end
        end

        always_ff @(posedge clk) begin
            dat_pipe[1] <= rd_now;
            for (int s = 2; s <= STAGES; s++) dat_pipe[s] <= dat_pipe[s-1];
        end

        assign push   = vld_pipe[STAGES];
        assign push_d = dat_pipe[STAGES];
    end

    resp_fifo #(.W($bits(fetch_resp_t)), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_d),
        .pop       (resp_ready),
        .empty     (empty),
        .head      (head)
    );

    assign resp_valid = !empty;
    assign resp_data  = empty ? '0 : head.data;
    assign resp_err   = !empty && head.err;
    assign resp_hs    = resp_valid && resp_ready;

    // One credit per buffer slot, held from acceptance until the response leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRED_W'(RESP_DEPTH);
        end else begin
            case ({accept, resp_hs})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready = (credits != '0);

endmodule
